operand_forward_stage: RTL

Consumer end of the hazard interface: takes the per-operand forward selects and the decode-to-execute enable from the hazard unit, then resolves operands A/B in decode.
- Registers the resolved operands and control into the execute stage, inserting a bubble on stall.
- Keeps the execute-to-memory-access copy of the ALU result, which is the source for the MEM_ACCESS_ALU_OPERAND path.
- Provides stall and bubble accounting, plus a sticky flag for protocol violations.

---
 rtl/operand_forward_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/operand_forward_stage.sv
// Decode-stage operand forwarding, decode->execute and execute->memory-access
// pipeline registers, stall accounting and a sticky forwarding-protocol flag.
module operand_forward_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGISTER_SIZE = 5,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     d_to_e_enable_ff,
    input  logic [1:0][1:0]          pipeline_forward_sel,
    input  logic                     d_valid,
    input  logic [DATA_WIDTH-1:0]    rf_data_a,
    input  logic [DATA_WIDTH-1:0]    rf_data_b,
    input  logic [REGISTER_SIZE-1:0] d_destination_reg,
    input  logic                     d_dm_read_enable,
    input  logic                     d_write_enable,
    input  logic [DATA_WIDTH-1:0]    alu_data_out,
    input  logic [DATA_WIDTH-1:0]    dm_data_out,
    output logic [DATA_WIDTH-1:0]    e_operand_a,
    output logic [DATA_WIDTH-1:0]    e_operand_b,
    output logic [REGISTER_SIZE-1:0] e_destination_reg,
    output logic                     e_dm_read_enable,
    output logic                     e_write_enable,
    output logic                     e_valid,
    output logic [DATA_WIDTH-1:0]    m_alu_data,
    output logic                     m_dm_read_enable,
    output logic                     m_valid,
    output logic [COUNTER_WIDTH-1:0] stall_count,
    output logic                     fwd_error
);

    localparam logic [1:0] SEL_RF      = 2'd0;
    localparam logic [1:0] SEL_MEM_DM  = 2'd1;
    localparam logic [1:0] SEL_EXE_ALU = 2'd2;
    localparam logic [1:0] SEL_MEM_ALU = 2'd3;

    logic [1:0][DATA_WIDTH-1:0] rf_data;
    logic [1:0][DATA_WIDTH-1:0] fwd_data;
    logic                       sel_illegal;
    logic                       d_accept;

    assign rf_data[0] = rf_data_a;
    assign rf_data[1] = rf_data_b;
    assign d_accept   = d_valid & d_to_e_enable_ff;

    always_comb begin
        fwd_data    = '0;
        sel_illegal = 1'b0;
        for (int i = 0; i < 2; i++) begin
            case (pipeline_forward_sel[i])
                SEL_RF: begin
                    fwd_data[i] = rf_data[i];
                end
                SEL_MEM_DM: begin
                    fwd_data[i] = dm_data_out;
                    if (!m_dm_read_enable) sel_illegal = 1'b1;
                end
                SEL_EXE_ALU: begin
                    // a load in execute has no ALU-ready result yet
                    fwd_data[i] = alu_data_out;
                    if (!e_valid || e_dm_read_enable) sel_illegal = 1'b1;
                end
                SEL_MEM_ALU: begin
                    fwd_data[i] = m_alu_data;
                    if (!m_valid || m_dm_read_enable) sel_illegal = 1'b1;
                end
                default: begin
                    fwd_data[i] = rf_data[i];
                end
            endcase
        end
    end

    // A disabled transfer loads a bubble: all execute fields cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_operand_a       <= '0;
            e_operand_b       <= '0;
            e_destination_reg <= '0;
            e_dm_read_enable  <= 1'b0;
            e_write_enable    <= 1'b0;
            e_valid           <= 1'b0;
        end else if (d_to_e_enable_ff) begin
            e_operand_a       <= fwd_data[0];
            e_operand_b       <= fwd_data[1];
            e_destination_reg <= d_destination_reg;
            e_dm_read_enable  <= d_dm_read_enable & d_valid;
            e_write_enable    <= d_write_enable & d_valid;
            e_valid           <= d_valid;
        end else begin
            e_operand_a       <= '0;
            e_operand_b       <= '0;
            e_destination_reg <= '0;
            e_dm_read_enable  <= 1'b0;
            e_write_enable    <= 1'b0;
            e_valid           <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_alu_data       <= '0;
            m_dm_read_enable <= 1'b0;
            m_valid          <= 1'b0;
        end else begin
            m_alu_data       <= alu_data_out;
            m_dm_read_enable <= e_dm_read_enable;
            m_valid          <= e_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            fwd_error   <= 1'b0;
        end else begin
            if (!d_to_e_enable_ff && d_valid && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (d_accept && sel_illegal) begin
                fwd_error <= 1'b1;
            end
        end
    end

endmodule
